pc_gen: RTL and testbench

//  Parametrised program-counter generator for the IFU. It holds the fetch PC
//  and offers it to fetch over a valid/ready handshake. It auto-increments on

---
 rtl/pc_gen_if.sv | 20 ++
 rtl/pc_gen.sv | 139 +++++++++++++
 tb/tb_pc_gen.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// rtl/pc_gen_if.sv - fetch-side PC offer handshake between pc_gen and the fetch stage
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pc_o;
  logic            pc_valid_o;
  logic            pc_ready_i;

  modport master (
    output pc_o,
    output pc_valid_o,
    input  pc_ready_i
  );

  modport slave (
    input  pc_o,
    input  pc_valid_o,
    output pc_ready_i
  );
endinterface

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - IFU program-counter generator with redirect priority and window/alignment fault parking
module pc_gen #(
  parameter int             XLEN      = 32,
  parameter logic [XLEN-1:0] BOOT_ADDR = '0,
  parameter int unsigned    MEM_DEPTH = 4096,
  parameter int unsigned    INC       = 4,
  parameter int unsigned    ALIGN_LG2 = 2
) (
  input  logic            clk,
  input  logic            rst,
  pc_gen_if.master        fetch,
  input  logic            stall_i,
  input  logic            br_en_i,
  input  logic [XLEN-1:0] br_addr_i,
  input  logic            trap_en_i,
  input  logic [XLEN-1:0] trap_addr_i,
  output logic            fault_o,
  output logic [XLEN-1:0] fault_addr_o,
  input  logic            fault_clr_i
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  // Window bounds and increment carry one extra bit so run-off past 2^XLEN is caught.
  localparam logic [XLEN:0]   W_LO       = {1'b0, BOOT_ADDR};
  localparam logic [XLEN:0]   W_HI       = W_LO + (XLEN+1)'(MEM_DEPTH);
  localparam logic [XLEN:0]   W_INC      = (XLEN+1)'(INC);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_LG2) - 64'd1);

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_valid;
  logic            r_fault;
  logic [XLEN-1:0] r_fault_addr;

  state_t          w_state_nx;
  logic [XLEN-1:0] w_pc_nx;
  logic            w_valid_nx;
  logic            w_fault_nx;
  logic [XLEN-1:0] w_faddr_nx;

  logic [XLEN:0]   w_seq;
  logic [XLEN:0]   w_tgt;
  logic            w_have_tgt;
  logic            w_tgt_legal;
  logic            w_trap_legal;

  function automatic logic f_legal(input logic [XLEN:0] a);
    return (a[XLEN] == 1'b0) && (a >= W_LO) && (a < W_HI) &&
           ((a[XLEN-1:0] & ALIGN_MASK) == '0);
  endfunction

  assign w_seq        = {1'b0, r_pc} + W_INC;
  assign w_trap_legal = f_legal({1'b0, trap_addr_i});
  assign w_tgt_legal  = f_legal(w_tgt);

  // Redirects beat the sequential step and ignore stall/ready entirely.
  always_comb begin
    w_have_tgt = 1'b1;
    w_tgt      = {1'b0, r_pc};
    if (trap_en_i) begin
      w_tgt = {1'b0, trap_addr_i};
    end else if (br_en_i) begin
      w_tgt = {1'b0, br_addr_i};
    end else if (r_valid && fetch.pc_ready_i && !stall_i) begin
      w_tgt = w_seq;
    end else begin
      w_have_tgt = 1'b0;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_valid_nx = 1'b0;
    w_fault_nx = r_fault & ~fault_clr_i;
    w_faddr_nx = r_fault_addr;
    case (r_state)
      S_BOOT: begin
        w_state_nx = S_RUN;
        w_valid_nx = 1'b1;
      end
      S_RUN: begin
        w_valid_nx = 1'b1;
        if (w_have_tgt) begin
          if (w_tgt_legal) begin
            w_pc_nx = w_tgt[XLEN-1:0];
          end else begin
            w_fault_nx = 1'b1;
            w_faddr_nx = w_tgt[XLEN-1:0];
            w_valid_nx = 1'b0;
            w_state_nx = S_FAULT;
          end
        end
      end
      S_FAULT: begin
        // Only a legal trap vector can un-park the generator.
        if (trap_en_i) begin
          if (w_trap_legal) begin
            w_pc_nx    = trap_addr_i;
            w_valid_nx = 1'b1;
            w_state_nx = S_RUN;
          end else begin
            w_faddr_nx = trap_addr_i;
          end
        end
      end
      default: begin
        w_state_nx = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_BOOT;
      r_pc         <= BOOT_ADDR;
      r_valid      <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_pc         <= w_pc_nx;
      r_valid      <= w_valid_nx;
      r_fault      <= w_fault_nx;
      r_fault_addr <= w_faddr_nx;
    end
  end

  assign fetch.pc_o       = r_pc;
  assign fetch.pc_valid_o = r_valid;
  assign fault_o          = r_fault;
  assign fault_addr_o     = r_fault_addr;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - scoreboard bench for pc_gen: model predicts each edge, checker compares after it
module tb_pc_gen;
  localparam int          XLEN = 32;
  localparam longint      BOOT = 0;
  localparam longint      MEM  = 4096;
  localparam longint      STEP = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            stall_i, br_en_i, trap_en_i, fault_clr_i;
  logic [XLEN-1:0] br_addr_i, trap_addr_i;
  logic            fault_o;
  logic [XLEN-1:0] fault_addr_o;

  always #5 clk = ~clk;

  pc_gen_if #(.XLEN(XLEN)) fetch_if ();

  pc_gen #(
    .XLEN(XLEN), .BOOT_ADDR(32'h0), .MEM_DEPTH(4096), .INC(4), .ALIGN_LG2(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch        (fetch_if),
    .stall_i      (stall_i),
    .br_en_i      (br_en_i),
    .br_addr_i    (br_addr_i),
    .trap_en_i    (trap_en_i),
    .trap_addr_i  (trap_addr_i),
    .fault_o      (fault_o),
    .fault_addr_o (fault_addr_o),
    .fault_clr_i  (fault_clr_i)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic        fault;
    logic [31:0] faddr;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  int          m_state;
  logic [31:0] m_pc, m_faddr;
  logic        m_valid, m_fault;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit legal(input longint unsigned a);
    return (a >= BOOT) && (a < BOOT + MEM) && ((a % STEP) == 0);
  endfunction

  task automatic model_reset();
    m_state = 0; m_pc = 32'h0; m_valid = 1'b0; m_fault = 1'b0; m_faddr = 32'h0;
  endtask

  task automatic model_step();
    longint unsigned t;
    bit              have;
    if (fault_clr_i) m_fault = 1'b0;
    if (m_state == 0) begin
      m_state = 1; m_valid = 1'b1;
    end else if (m_state == 1) begin
      have = 1'b1;
      if (trap_en_i)                                           t = trap_addr_i;
      else if (br_en_i)                                        t = br_addr_i;
      else if (m_valid && fetch_if.pc_ready_i && !stall_i)     t = longint'(m_pc) + STEP;
      else                                                     have = 1'b0;
      if (have) begin
        if (legal(t)) m_pc = t[31:0];
        else begin
          m_fault = 1'b1; m_faddr = t[31:0]; m_valid = 1'b0; m_state = 2;
        end
      end
    end else if (trap_en_i) begin
      if (legal(trap_addr_i)) begin
        m_pc = trap_addr_i; m_valid = 1'b1; m_state = 1;
      end else m_faddr = trap_addr_i;
    end
  endtask

  task automatic step(input string tag);
    exp_t e;
    model_step();
    sb_q.push_back({m_pc, m_valid, m_fault, m_faddr});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq({tag, ".pc"},    64'(fetch_if.pc_o),       64'(e.pc));
    check_eq({tag, ".valid"}, 64'(fetch_if.pc_valid_o), 64'(e.valid));
    check_eq({tag, ".fault"}, 64'(fault_o),             64'(e.fault));
    check_eq({tag, ".faddr"}, 64'(fault_addr_o),        64'(e.faddr));
  endtask

  task automatic drive(input logic rdy, input logic stl, input logic br, input logic [31:0] ba,
                       input logic tr, input logic [31:0] ta, input logic clr);
    fetch_if.pc_ready_i = rdy; stall_i = stl; br_en_i = br; br_addr_i = ba;
    trap_en_i = tr; trap_addr_i = ta; fault_clr_i = clr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check_eq("rst.pc", 64'(fetch_if.pc_o), 64'h0);
    check_eq("rst.valid", 64'(fetch_if.pc_valid_o), 64'h0);
    check_eq("rst.fault", 64'(fault_o), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // T1: boot then sequential fetch
    for (int i = 0; i < 5; i++) step("t1");
    check_eq("t1.pc_end", 64'(fetch_if.pc_o), 64'h10);

    // T2: stall blocks advance, branch ignores stall
    drive(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("t2_stall");
    check_eq("t2.hold", 64'(fetch_if.pc_o), 64'h10);
    drive(1, 1, 1, 32'h40, 0, 0, 0);
    step("t2_br");
    check_eq("t2.br", 64'(fetch_if.pc_o), 64'h40);
    drive(0, 0, 0, 0, 0, 0, 0);
    step("t2_noready");

    // T3: trap beats branch
    drive(1, 0, 1, 32'h40, 1, 32'h80, 0);
    step("t3");
    check_eq("t3.trap", 64'(fetch_if.pc_o), 64'h80);

    // T4: out-of-window branch, parked, trap recovery, clear
    drive(1, 0, 1, 32'h1000, 0, 0, 0);
    step("t4_fault");
    check_eq("t4.faddr", 64'(fault_addr_o), 64'h1000);
    check_eq("t4.valid", 64'(fetch_if.pc_valid_o), 64'h0);
    check_eq("t4.pc", 64'(fetch_if.pc_o), 64'h80);
    drive(1, 0, 1, 32'h20, 0, 0, 0);
    step("t4_br_ign");
    drive(1, 0, 0, 0, 1, 32'h100, 0);
    step("t4_trap");
    check_eq("t4.recov_pc", 64'(fetch_if.pc_o), 64'h100);
    check_eq("t4.sticky", 64'(fault_o), 64'h1);
    drive(1, 0, 0, 0, 0, 0, 1);
    step("t4_clr");
    check_eq("t4.cleared", 64'(fault_o), 64'h0);

    // T5: run-off at window end, then misaligned branch
    drive(1, 0, 1, 32'hFF8, 0, 0, 0);
    step("t5_br");
    drive(1, 0, 0, 0, 0, 0, 0);
    step("t5_ffc");
    check_eq("t5.pc_ffc", 64'(fetch_if.pc_o), 64'hFFC);
    step("t5_runoff");
    check_eq("t5.runoff_faddr", 64'(fault_addr_o), 64'h1000);
    check_eq("t5.runoff_valid", 64'(fetch_if.pc_valid_o), 64'h0);
    drive(1, 0, 0, 0, 1, 32'h7FF0, 0);
    step("t5_bad_trap");
    check_eq("t5.bad_trap_faddr", 64'(fault_addr_o), 64'h7FF0);
    drive(1, 0, 0, 0, 1, 32'h0, 0);
    step("t5_recov");
    drive(1, 0, 1, 32'h42, 0, 0, 1);
    step("t5_misalign");
    check_eq("t5.mis_faddr", 64'(fault_addr_o), 64'h42);
    check_eq("t5.clr_loses", 64'(fault_o), 64'h1);
    drive(1, 0, 0, 0, 1, 32'h200, 0);
    step("t5_recov2");

    // Mixed random traffic against the model
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = (($urandom_range(0, 3) == 0) ? $urandom_range(0, 32'h1100) : ($urandom_range(0, 1023) * 4));
      drive($urandom_range(0, 1), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), a,
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 1023) * 4), ($urandom_range(0, 5) == 0));
      step("rnd");
    end

    // T6: async reset from FAULT
    drive(1, 0, 1, 32'h2000, 0, 0, 0);
    step("t6_fault");
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6.pc", 64'(fetch_if.pc_o), 64'h0);
    check_eq("t6.valid", 64'(fetch_if.pc_valid_o), 64'h0);
    check_eq("t6.fault", 64'(fault_o), 64'h0);
    check_eq("t6.faddr", 64'(fault_addr_o), 64'h0);
    sb_q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0);
    #1;
    step("t6_boot");
    step("t6_run");
    check_eq("t6.run_pc", 64'(fetch_if.pc_o), 64'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
